// File: rtl/buzzer_pkg.sv
// rtl/buzzer_pkg.sv - shared types, reload defaults and width helper for the beep sequencer
package buzzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int TICK_RLD_DEFAULT          = 99_999;
  localparam int TICK_RLD_TURBOSIM_DEFAULT = 9;

  // Number of bits needed to hold value (at least 1).
  function automatic int wordlength(input int unsigned value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/buzzer_seq_if.sv
// rtl/buzzer_seq_if.sv - request/busy/done handshake and pattern parameters
interface buzzer_seq_if #(
  parameter int TONE_W = 16,
  parameter int DUR_W  = 10,
  parameter int CNT_W  = 4
);
  logic              start;
  logic              abort;
  logic [TONE_W-1:0] tone_half;
  logic [DUR_W-1:0]  on_ms;
  logic [DUR_W-1:0]  off_ms;
  logic [CNT_W-1:0]  beeps;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, tone_half, on_ms, off_ms, beeps,
    input  busy, done
  );

  modport slave (
    input  start, abort, tone_half, on_ms, off_ms, beeps,
    output busy, done
  );
endinterface

// File: rtl/buzzer_tone.sv
// rtl/buzzer_tone.sv - tone half-period down-counter and toggle flop
module buzzer_tone #(
  parameter int TONE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [TONE_W-1:0] half,
  output logic              tone
);

  logic [TONE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (!run) begin
      cnt  <= half;
      tone <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= half;
      tone <= ~tone;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/buzzer_seq.sv
// rtl/buzzer_seq.sv - programmable beep-sequence generator driving the piezo differentially
module buzzer_seq
  import buzzer_pkg::*;
#(
  parameter int TICK_RLD          = TICK_RLD_DEFAULT,
  parameter int TICK_RLD_TURBOSIM = TICK_RLD_TURBOSIM_DEFAULT,
  parameter int TONE_W            = 16,
  parameter int DUR_W             = 10,
  parameter int CNT_W             = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         turbosim,
  buzzer_seq_if.slave  bus,
  output logic         buzzer_p,
  output logic         buzzer_n
);

  localparam int TICK_MAX = (TICK_RLD > TICK_RLD_TURBOSIM) ? TICK_RLD : TICK_RLD_TURBOSIM;
  localparam int TICK_W   = wordlength(TICK_MAX);

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] tick_rld;
  logic [DUR_W-1:0]  ms_cnt;
  logic [DUR_W-1:0]  on_q;
  logic [DUR_W-1:0]  off_q;
  logic [DUR_W-1:0]  on_in;
  logic [TONE_W-1:0] tone_q;
  logic [TONE_W-1:0] half_src;
  logic [CNT_W-1:0]  remaining;
  logic              busy_q;
  logic              done_q;
  logic              phase_end;
  logic              tone_run;
  logic              tone;

  // The tone is stopped in the last cycle of every ON phase so the next
  // phase (or OFF/DONE) starts with a silent, freshly reloaded generator.
  always_comb begin
    tick_rld  = turbosim ? TICK_W'(TICK_RLD_TURBOSIM) : TICK_W'(TICK_RLD);
    phase_end = (tick_cnt == '0) && (ms_cnt == DUR_W'(1));
    tone_run  = (state == ST_ON) && !phase_end && !bus.abort;
    half_src  = (state == ST_IDLE) ? bus.tone_half : tone_q;
    on_in     = (bus.on_ms == '0) ? DUR_W'(1) : bus.on_ms;
  end

  buzzer_tone #(.TONE_W(TONE_W)) u_tone (
    .clk   (clk),
    .reset (reset),
    .run   (tone_run),
    .half  (half_src),
    .tone  (tone)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      ms_cnt    <= '0;
      on_q      <= '0;
      off_q     <= '0;
      tone_q    <= '0;
      remaining <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            tone_q <= bus.tone_half;
            on_q   <= on_in;
            off_q  <= bus.off_ms;
            busy_q <= 1'b1;
            if (bus.beeps == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state     <= ST_ON;
              remaining <= bus.beeps;
              tick_cnt  <= tick_rld;
              ms_cnt    <= on_in;
            end
          end
        end
        ST_ON, ST_OFF: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (phase_end) begin
            tick_cnt <= tick_rld;
            if (state == ST_OFF) begin
              state  <= ST_ON;
              ms_cnt <= on_q;
            end else if (remaining == CNT_W'(1)) begin
              state     <= ST_DONE;
              remaining <= '0;
              done_q    <= 1'b1;
            end else begin
              remaining <= remaining - 1'b1;
              if (off_q == '0) begin
                state  <= ST_ON;
                ms_cnt <= on_q;
              end else begin
                state  <= ST_OFF;
                ms_cnt <= off_q;
              end
            end
          end else if (tick_cnt == '0) begin
            tick_cnt <= tick_rld;
            ms_cnt   <= ms_cnt - 1'b1;
          end else begin
            tick_cnt <= tick_cnt - 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign buzzer_p = tone;
  assign buzzer_n = (state == ST_ON) & ~tone;

endmodule

// File: tb/tb_buzzer_seq.sv
// tb/tb_buzzer_seq.sv - directed, table-driven bench for the beep sequencer
module tb_buzzer_seq;

  localparam int TB_TICK_RLD = 499;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic turbosim = 1'b1;
  logic buzzer_p;
  logic buzzer_n;

  buzzer_seq_if bus ();

  always #5 clk = ~clk;

  buzzer_seq #(.TICK_RLD(TB_TICK_RLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .turbosim (turbosim),
    .bus      (bus),
    .buzzer_p (buzzer_p),
    .buzzer_n (buzzer_n)
  );

  typedef struct {
    int tone_half;
    int on_ms;
    int off_ms;
    int beeps;
    int poke;
    int exp_busy;
  } scn_t;

  scn_t scns[7];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_params(input int th, input int on, input int off, input int n);
    bus.tone_half = 16'(th);
    bus.on_ms     = 10'(on);
    bus.off_ms    = 10'(off);
    bus.beeps     = 4'(n);
  endtask

  // Expected {busy, done, buzzer_p, buzzer_n} in cycle k+t (1 ms = 10 clocks).
  function automatic logic [3:0] exp_out(input scn_t s, input int t);
    int on_len, off_len, total, pos;
    logic p;
    on_len  = ((s.on_ms == 0) ? 1 : s.on_ms) * 10;
    off_len = s.off_ms * 10;
    if (s.beeps == 0) return (t == 1) ? 4'b1100 : 4'b0000;
    total = s.beeps * on_len + (s.beeps - 1) * off_len;
    if (t == total + 1) return 4'b1100;
    if (t > total) return 4'b0000;
    pos = (t - 1) % (on_len + off_len);
    if (pos >= on_len) return 4'b1000;
    p = ((pos / (s.tone_half + 1)) % 2) == 1;
    return {1'b1, 1'b0, p, ~p};
  endfunction

  function automatic logic [3:0] sample();
    return {bus.busy, bus.done, buzzer_p, buzzer_n};
  endfunction

  task automatic launch(input int th, input int on, input int off, input int n);
    @(posedge clk); #1;
    set_params(th, on, off, n);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_scn(input int idx, input scn_t s);
    int busy_cnt;
    logic [3:0] act;
    busy_cnt = 0;
    launch(s.tone_half, s.on_ms, s.off_ms, s.beeps);
    for (int t = 1; t <= s.exp_busy + 2; t++) begin
      if (s.poke != 0 && t == s.poke) begin
        set_params(9, 1, 0, 5);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      act = sample();
      if (act[3]) busy_cnt++;
      check($sformatf("scn%0d_t%0d", idx, t), int'(act), int'(exp_out(s, t)));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check($sformatf("scn%0d_busy_len", idx), busy_cnt, s.exp_busy);
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check(name, int'(bus.busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int done_seen, busy_cnt, on_cnt, done_cnt;
    scn_t basic;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    set_params(2, 3, 2, 2);

    scns[0] = '{2, 3, 2, 2, 0, 81};
    scns[1] = '{0, 1, 1, 3, 0, 51};
    scns[2] = '{5, 0, 0, 2, 0, 21};
    scns[3] = '{1, 2, 0, 0, 0, 1};
    scns[4] = '{3, 1, 3, 1, 0, 11};
    scns[5] = '{20, 1, 0, 1, 0, 11};
    scns[6] = '{2, 3, 2, 2, 5, 81};
    basic = scns[0];

    // Reset held for 3 cycles with start high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_c%0d", i), int'(sample()), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("no_start_after_reset", int'(sample()), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_scn(i, scns[i]);

    // Abort at k+12, new start accepted at k+13.
    launch(2, 3, 2, 2);
    done_seen = 0;
    for (int t = 1; t <= 11; t++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
      if (t == 1) check("abort_first_on", int'(sample()), 4'b1001);
      @(posedge clk); #1;
    end
    bus.abort = 1'b1;
    @(negedge clk);
    check("abort_cycle", int'(sample()), int'(exp_out(basic, 12)));
    @(posedge clk); #1;
    bus.abort = 1'b0;
    set_params(0, 1, 0, 1);
    bus.start = 1'b1;
    @(negedge clk);
    if (bus.done) done_seen++;
    check("abort_idle", int'(sample()), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("restart_after_abort", int'(sample()), 4'b1001);
    check("abort_no_done", done_seen, 0);
    wait_idle("restart_completes");

    // Reset in the middle of the OFF gap.
    launch(2, 3, 2, 2);
    for (int t = 1; t <= 39; t++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("off_before_reset", int'(sample()), 4'b1000);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_mid_off", int'(sample()), 0);
    @(posedge clk); #1;
    run_scn(7, basic);

    // Real-time tick: one ON phase of on_ms * (TB_TICK_RLD+1) clocks.
    turbosim = 1'b0;
    launch(7, 2, 0, 1);
    busy_cnt = 0;
    on_cnt   = 0;
    done_cnt = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!bus.busy) break;
      busy_cnt++;
      if (buzzer_p | buzzer_n) on_cnt++;
      if (bus.done) done_cnt++;
    end
    check("slow_on_len", on_cnt, 2 * (TB_TICK_RLD + 1));
    check("slow_busy_len", busy_cnt, 2 * (TB_TICK_RLD + 1) + 1);
    check("slow_done", done_cnt, 1);
    turbosim = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzzer_seq.md
# buzzer_seq

Programmable beep-sequence generator that drives the board piezo buzzer differentially. It replaces the single fixed-tone, fixed-duration buzzer with run-time selectable tone pitch, on/off durations in milliseconds and beep count. A request/busy/done handshake lets any controller FSM trigger a pattern, for example one short beep for a key press or three beeps for an alarm. It sits between the application control logic and the buzzer_p/buzzer_n pins.

## Interface
- TICK_RLD, 99_999: clocks per 1 ms tick, minus 1 (100 MHz clk)
- TICK_RLD_TURBOSIM, 9: tick reload used when turbosim=1
- TONE_W, 16: width of tone half-period input
- DUR_W, 10: width of on/off duration inputs (ms)
- CNT_W, 4: width of beep count input

- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- turbosim  in  1  selects TICK_RLD_TURBOSIM
- start  in  1  request pulse; accepted only in IDLE
- abort  in  1  terminates any sequence; priority over start
- tone_half  in  TONE_W  tone half-period = tone_half+1 clocks
- on_ms  in  DUR_W  beep length, ms (0 treated as 1)
- off_ms  in  DUR_W  gap length, ms (0 = no gap)
- beeps  in  CNT_W  number of beeps (0 = none)
- busy  out  1  high from acceptance until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- buzzer_p  out  1  buzzer positive terminal
- buzzer_n  out  1  buzzer negative terminal

## Operation
- States: IDLE, ON, OFF, DONE.
- IDLE + start (abort=0):
  - capture tone_half, on_ms, off_ms and beeps into internal registers; later input changes are ignored until IDLE.
  - if beeps==0, go to DONE; otherwise go to ON with remaining := beeps.
- ON:
  - tone generator active, buzzer_p = tone, buzzer_n = ~tone.
  - tone starts at 0 on entry, toggles each time its down-counter reaches 0, then reloads tone_half.
  - when phase ends: remaining decrements; if it reaches 0, go to DONE; else if off_ms==0, go directly to ON (new phase, tone restarts at 0); else go to OFF.
- OFF: buzzer_p = buzzer_n = 0, tone counter held at reload; at phase end go to ON.
- DONE: done=1 for exactly one cycle, busy=1, outputs 0; next state IDLE.
- Phase timing:
  - tick prescaler reloads on every phase entry, so phase length is exact: on_ms*(R+1) clocks for ON and off_ms*(R+1) for OFF.
  - R = TICK_RLD, or TICK_RLD_TURBOSIM when turbosim=1. turbosim is sampled continuously.
  - ms counter is DUR_W bits and loaded with max(on_ms,1) or off_ms; no wrap is possible.
- abort=1 in any non-IDLE state: next state is IDLE, no done pulse, outputs 0 from the next cycle.
- start while busy is ignored; it is not queued.
- Outputs are never both 1. In IDLE, OFF and DONE both are 0.

## Timing
- All outputs are registered. Reset value: busy=0, done=0, buzzer_p=0, buzzer_n=0, state IDLE, all counters 0.
- start sampled at edge k: busy=1 and state ON from k+1, with buzzer_p=0 and buzzer_n=1.
- First tone toggle is at k+1+(tone_half+1).
- Total busy duration for N≥1 beeps: N*on + (N-1)*off + 1 (DONE) cycles, in ticks converted to clocks.
- beeps==0: busy=1 and done=1 in cycle k+1 only; IDLE at k+2.
- reset mid-sequence: reset values in the next cycle; no done pulse.

## Structure
- Package buzzer_pkg holds:
  - state encoding (IDLE=0, ON=1, OFF=2, DONE=3)
  - default TICK_RLD and TICK_RLD_TURBOSIM values
  - the wordlength function
- Sub-module buzzer_tone holds the tone half-period down-counter and toggle flop.
  - ports: clk, reset, run, half, tone
  - run=0 forces tone=0 and reloads the counter.
- Top level holds the FSM, tick prescaler, ms counter, beep counter and output logic. Target size is about 200 lines.

## Test plan
All scenarios use turbosim=1, so 1 ms = 10 clocks.
- Reset: assert reset for 3 cycles with start=1 -> busy, done, buzzer_p and buzzer_n all 0; no sequence starts.
- Basic pattern: tone_half=2, on_ms=3, off_ms=2, beeps=2, start at k.
  - ON during k+1..k+30, buzzer_p toggling every 3 clocks with buzzer_n its complement.
  - OFF during k+31..k+50 with both outputs 0.
  - ON during k+51..k+80.
  - done=1 at k+81; busy=0 at k+82.
- Edge values, run as separate sequences: beeps=0 -> done at k+1 with no buzz; on_ms=0 -> ON lasts 10 clocks; tone_half=0 -> buzzer_p toggles every clock.
- Busy protection: a second start at k+5 with different parameters -> ignored; timing identical to the basic pattern.
- Abort: abort at k+12 -> both outputs 0 and busy=0 at k+13; done never asserted. A start at k+13 is accepted.
- Reset mid-OFF: reset at k+40 -> outputs at reset values at k+41; a new start afterwards runs normally. Also toggle turbosim=0 and check one ON phase lasts on_ms*100_000 clocks.
